tinsel_acc_flit_in_queue: RTL

//   Input flit buffer sitting directly upstream of an external Tinsel accelerator, between the NoC

---
 rtl/tinsel_noc_pkg.sv | 18 +
 rtl/tinsel_flit_fifo_mem.sv | 18 +
 rtl/tinsel_acc_flit_in_queue.sv | 58 +++++
 3 files changed

// File: rtl/tinsel_noc_pkg.sv
// tinsel_noc_pkg: NoC address and flit types shared by the flit queue and the accelerator
package tinsel_noc_pkg;
  typedef struct packed {
    logic       acc;
    logic [1:0] board_y;
    logic [1:0] board_x;
    logic [2:0] mbox_y;
    logic [2:0] mbox_x;
    logic [5:0] thread;
  } NetAddr;
  typedef struct packed {
    NetAddr      dest;
    logic        not_final_flit;
    logic        is_idle_token;
    logic [63:0] payload;
  } Flit;
  localparam int FLIT_WIDTH = $bits(Flit);
endpackage

// File: rtl/tinsel_flit_fifo_mem.sv
// tinsel_flit_fifo_mem: 2**LOG_DEPTH x FLIT_WIDTH register array (clk, we/waddr/wdata write port, raddr/rdata async read port)
module tinsel_flit_fifo_mem
  import tinsel_noc_pkg::*;
#(
  parameter int LOG_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG_DEPTH-1:0]  waddr,
  input  logic [FLIT_WIDTH-1:0] wdata,
  input  logic [LOG_DEPTH-1:0]  raddr,
  output logic [FLIT_WIDTH-1:0] rdata
);
  logic [FLIT_WIDTH-1:0] mem [2**LOG_DEPTH];
  always_ff @(negedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/tinsel_acc_flit_in_queue.sv
// tinsel_acc_flit_in_queue: idle-filtering flit FIFO (in_* from NoC, out_* to accelerator, count/almost_full/idle_count status)
module tinsel_acc_flit_in_queue
  import tinsel_noc_pkg::*;
#(
  parameter int LOG_DEPTH = 2,
  parameter int AF_LEVEL  = 3,
  parameter int IDLE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  Flit                  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output Flit                  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOG_DEPTH:0]   count,
  output logic                 almost_full,
  output logic [IDLE_BITS-1:0] idle_count
);
  logic [LOG_DEPTH:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
  logic full, in_fire, out_fire, enq, idle;
  logic [FLIT_WIDTH-1:0] rd_word;
  assign in_ready  = !full;
  assign in_fire   = in_valid && in_ready;
  assign idle      = in_fire && in_data.is_idle_token;
  assign enq       = in_fire && !in_data.is_idle_token;
  assign out_valid = wr_ptr != rd_ptr;
  assign out_fire  = out_valid && out_ready;
  assign wr_nxt    = wr_ptr + (LOG_DEPTH+1)'(enq);
  assign rd_nxt    = rd_ptr + (LOG_DEPTH+1)'(out_fire);
  assign cnt_nxt   = wr_nxt - rd_nxt;
  assign count     = wr_ptr - rd_ptr;
  assign out_data  = Flit'(rd_word);
  tinsel_flit_fifo_mem #(.LOG_DEPTH(LOG_DEPTH)) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr[LOG_DEPTH-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[LOG_DEPTH-1:0]),
    .rdata (rd_word)
  );
  // full and almost_full are computed from next-state pointers so they are registered yet track count
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      idle_count  <= '0;
    end else begin
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      full        <= wr_nxt[LOG_DEPTH] != rd_nxt[LOG_DEPTH] && wr_nxt[LOG_DEPTH-1:0] == rd_nxt[LOG_DEPTH-1:0];
      almost_full <= cnt_nxt >= (LOG_DEPTH+1)'(AF_LEVEL);
      if (idle && idle_count != '1) idle_count <= idle_count + IDLE_BITS'(1);
    end
endmodule
